// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states and
// access-size helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_OP_B  = 3'd0,
        LSU_OP_H  = 3'd1,
        LSU_OP_W  = 3'd2,
        LSU_OP_BU = 3'd4,
        LSU_OP_HU = 3'd5
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Byte-enable pattern of an access, right-aligned (before lane shift).
    function automatic logic [3:0] lsu_size_mask(input logic [1:0] size_code);
        logic [3:0] mask;
        case (size_code)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic [2:0] lsu_size_bytes(input logic [1:0] size_code);
        logic [2:0] nbytes;
        case (size_code)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            2'd2:    nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
        return nbytes;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath of the LSU: mask and store-data shifting for the first
// or second word of an access, load capture merge and final extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [3:0]  szmask,
    input  logic        second,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] cap,
    input  logic [2:0]  funct3,
    output logic [3:0]  bmask,
    output logic [31:0] lane_wdata,
    output logic [31:0] cap_next,
    output logic [31:0] ext_data
);

    logic [7:0] mask_wide_s;
    logic [5:0] sh_lo_s;
    logic [5:0] sh_hi_s;

    // Lane shift amounts; the upper part of a crossing access lives in the second word.
    always_comb begin
        mask_wide_s = {4'b0000, szmask} << off;
        sh_lo_s     = {1'b0, off, 3'b000};
        sh_hi_s     = 6'd32 - sh_lo_s;
    end

    // Mask, store data and load merge for the current access word.
    always_comb begin
        if (second) begin
            bmask      = mask_wide_s[7:4];
            lane_wdata = wdata >> sh_hi_s;
            cap_next   = cap | (mem_rdata << sh_hi_s);
        end else begin
            bmask      = mask_wide_s[3:0];
            lane_wdata = wdata << sh_lo_s;
            cap_next   = mem_rdata >> sh_lo_s;
        end
    end

    // Truncate the merged capture to the access size and extend.
    always_comb begin
        case (funct3)
            LSU_OP_B:  ext_data = {{24{cap_next[7]}}, cap_next[7:0]};
            LSU_OP_H:  ext_data = {{16{cap_next[15]}}, cap_next[15:0]};
            LSU_OP_W:  ext_data = cap_next;
            LSU_OP_BU: ext_data = {24'h000000, cap_next[7:0]};
            LSU_OP_HU: ext_data = {16'h0000, cap_next[15:0]};
            default:   ext_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a byte-masked, asynchronously read data memory.
// Build option LSU_MISALIGN_SPLIT_EN: word-crossing accesses are split in two.
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);
    import lsu_pkg::*;

    localparam logic [ADDR_W-1:0] WORD_STRIDE = {{(ADDR_W-3){1'b0}}, 3'b100};

    lsu_state_e        state_r;
    lsu_state_e        state_next_s;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       cap_r;
    logic              ready_r;
    logic              done_r;
    logic              err_r;
    logic [31:0]       rdata_r;

    logic              f3_bad_s;
    logic              misalign_s;
    logic              req_err_s;
    logic              crossing_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [3:0]        bmask_s;
    logic [31:0]       lane_wdata_s;
    logic [31:0]       cap_next_s;
    logic [31:0]       ext_data_s;

    // Legality of the incoming request: funct3 encoding and alignment.
    always_comb begin
        case (i_funct3)
            LSU_OP_B, LSU_OP_H, LSU_OP_W: f3_bad_s = 1'b0;
            LSU_OP_BU, LSU_OP_HU:         f3_bad_s = i_we;
            default:                      f3_bad_s = 1'b1;
        endcase
`ifdef LSU_MISALIGN_SPLIT_EN
        misalign_s = 1'b0;
`else
        case (i_funct3[1:0])
            2'd1:    misalign_s = i_addr[0];
            2'd2:    misalign_s = |i_addr[1:0];
            default: misalign_s = 1'b0;
        endcase
`endif
        req_err_s = f3_bad_s | misalign_s;
    end

    // Whether the latched access spills into the following word.
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        crossing_s = (({1'b0, addr_r[1:0]} + lsu_size_bytes(funct3_r[1:0])) > 3'd4);
`else
        crossing_s = 1'b0;
`endif
        word_addr_s = {addr_r[ADDR_W-1:2], 2'b00};
    end

    lsu_align u_align (
        .off        (addr_r[1:0]),
        .szmask     (lsu_size_mask(funct3_r[1:0])),
        .second     (state_r == ST_ACC1),
        .wdata      (wdata_r),
        .mem_rdata  (i_mem_rdata),
        .cap        (cap_r),
        .funct3     (funct3_r),
        .bmask      (bmask_s),
        .lane_wdata (lane_wdata_s),
        .cap_next   (cap_next_s),
        .ext_data   (ext_data_s)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; rejected requests go straight to the response.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_req) begin
                    state_next_s = req_err_s ? ST_RESP : ST_ACC0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC0: state_next_s = crossing_s ? ST_ACC1 : ST_RESP;
            ST_ACC1: state_next_s = ST_RESP;
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs toward memory; decoded from state so reset kills a write at once.
    always_comb begin
        o_mem_addr  = {ADDR_W{1'b0}};
        o_mem_wdata = 32'h0000_0000;
        o_mem_bmask = 4'b0000;
        o_mem_wren  = 1'b0;
        case (state_r)
            ST_ACC0: begin
                o_mem_addr  = word_addr_s;
                o_mem_wdata = lane_wdata_s;
                o_mem_bmask = bmask_s;
                o_mem_wren  = we_r;
            end
            ST_ACC1: begin
                o_mem_addr  = word_addr_s + WORD_STRIDE;
                o_mem_wdata = lane_wdata_s;
                o_mem_bmask = bmask_s;
                o_mem_wren  = we_r;
            end
            default: begin
                o_mem_addr  = {ADDR_W{1'b0}};
                o_mem_wdata = 32'h0000_0000;
                o_mem_bmask = 4'b0000;
                o_mem_wren  = 1'b0;
            end
        endcase
    end

    // Request latch on accept and load-capture accumulation during ACC cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            we_r     <= 1'b0;
            funct3_r <= 3'd0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= 32'h0000_0000;
            cap_r    <= 32'h0000_0000;
        end else begin
            if ((state_r == ST_IDLE) && i_req) begin
                we_r     <= i_we;
                funct3_r <= i_funct3;
                addr_r   <= i_addr;
                wdata_r  <= i_wdata;
            end
            if (((state_r == ST_ACC0) || (state_r == ST_ACC1)) && !we_r) begin
                cap_r <= cap_next_s;
            end
        end
    end

    // Core-side response registers; load data is held until the next response.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            ready_r <= (state_next_s == ST_IDLE);
            done_r  <= (state_next_s == ST_RESP);
            err_r   <= (state_r == ST_IDLE) && (state_next_s == ST_RESP);
            if (state_next_s == ST_RESP) begin
                rdata_r <= ((state_r == ST_IDLE) || we_r) ? 32'h0000_0000 : ext_data_s;
            end
        end
    end

    assign o_ready = ready_r;
    assign o_done  = done_r;
    assign o_err   = err_r;
    assign o_rdata = rdata_r;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a byte-masked memory model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, err, mem_wren;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_bmask;

    logic [31:0] mem [16];

    int checks = 0;
    int failures = 0;

    int          acc_n;
    logic [31:0] acc_addr [2];
    logic [3:0]  acc_mask [2];
    logic [31:0] acc_wdata [2];
    int          lat;
    logic [31:0] r_data;
    logic        r_err;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_bmask[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    lsu #(.ADDR_W(32)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_funct3    (f3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_ready     (ready),
        .o_done      (done),
        .o_err       (err),
        .o_rdata     (rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_bmask (mem_bmask),
        .o_mem_wren  (mem_wren),
        .i_mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Issue one request and record memory traffic, latency and response.
    task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d);
        @(negedge clk);
        check("ready_idle", {31'b0, ready}, 32'd1);
        check("done_low", {31'b0, done}, 32'd0);
        req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        acc_n = 0; lat = 0; r_data = 32'h0; r_err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_wren || (mem_bmask != 4'b0000)) begin
                if (acc_n < 2) begin
                    acc_addr[acc_n]  = mem_addr;
                    acc_mask[acc_n]  = mem_bmask;
                    acc_wdata[acc_n] = mem_wdata;
                end
                acc_n++;
            end
            if (done) begin
                lat = k; r_data = rdata; r_err = err;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_wren", {31'b0, mem_wren}, 32'd0);
        check("rst_bmask", {28'b0, mem_bmask}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(1'b1, 3'd2, 32'h10, 32'h12345678);
        check("sw10_lat", lat, 32'd2);

        // Reset during ACC0 of a store must abort the write
        @(negedge clk);
        req = 1'b1; we = 1'b1; f3 = 3'd2; addr = 32'h10; wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("abort_wren_pre", {31'b0, mem_wren}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_wren_drop", {31'b0, mem_wren}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", {31'b0, ready}, 32'd1);
        rst_n = 1'b1;
        run_req(1'b0, 3'd2, 32'h10, 32'h0);
        check("abort_word4", r_data, 32'h12345678);

        run_req(1'b1, 3'd2, 32'h8, 32'hAABBCCDD);
        check("sw8_nacc", acc_n, 32'd1);
        check("sw8_addr", acc_addr[0], 32'h8);
        check("sw8_mask", {28'b0, acc_mask[0]}, 32'hF);
        check("sw8_wdata", acc_wdata[0], 32'hAABBCCDD);
        check("sw8_lat", lat, 32'd2);
        run_req(1'b0, 3'd2, 32'h8, 32'h0);
        check("lw8_data", r_data, 32'hAABBCCDD);
        check("lw8_err", {31'b0, r_err}, 32'd0);
        check("lw8_lat", lat, 32'd2);

        run_req(1'b1, 3'd0, 32'h5, 32'h80);
        check("sb5_addr", acc_addr[0], 32'h4);
        check("sb5_mask", {28'b0, acc_mask[0]}, 32'h2);
        check("sb5_wdata", acc_wdata[0], 32'h00008000);
        run_req(1'b0, 3'd0, 32'h5, 32'h0);
        check("lb5", r_data, 32'hFFFFFF80);
        run_req(1'b0, 3'd4, 32'h5, 32'h0);
        check("lbu5", r_data, 32'h00000080);

        run_req(1'b1, 3'd1, 32'h6, 32'hF00D);
        check("sh6_mask", {28'b0, acc_mask[0]}, 32'hC);
        check("sh6_wdata", acc_wdata[0], 32'hF00D0000);
        run_req(1'b0, 3'd1, 32'h6, 32'h0);
        check("lh6", r_data, 32'hFFFFF00D);
        run_req(1'b0, 3'd5, 32'h6, 32'h0);
        check("lhu6", r_data, 32'h0000F00D);

        // Illegal funct3 for loads and stores
        run_req(1'b0, 3'd3, 32'h8, 32'h0);
        check("ld_f3_err", {31'b0, r_err}, 32'd1);
        check("ld_f3_rdata", r_data, 32'h0);
        check("ld_f3_nacc", acc_n, 32'd0);
        check("ld_f3_lat", lat, 32'd1);
        run_req(1'b1, 3'd3, 32'h8, 32'h11111111);
        check("st_f3_err", {31'b0, r_err}, 32'd1);
        check("st_f3_nacc", acc_n, 32'd0);
        run_req(1'b1, 3'd4, 32'h8, 32'h22222222);
        check("st_f4_err", {31'b0, r_err}, 32'd1);
        run_req(1'b0, 3'd2, 32'h8, 32'h0);
        check("st_err_nowrite", r_data, 32'hAABBCCDD);

`ifdef LSU_MISALIGN_SPLIT_EN
        run_req(1'b1, 3'd2, 32'h2, 32'hAABBCCDD);
        check("split_nacc", acc_n, 32'd2);
        check("split_a0", acc_addr[0], 32'h0);
        check("split_m0", {28'b0, acc_mask[0]}, 32'hC);
        check("split_w0", acc_wdata[0], 32'hCCDD0000);
        check("split_a1", acc_addr[1], 32'h4);
        check("split_m1", {28'b0, acc_mask[1]}, 32'h3);
        check("split_w1", acc_wdata[1], 32'h0000AABB);
        check("split_lat", lat, 32'd3);
        run_req(1'b1, 3'd2, 32'h0, 32'h44332211);
        run_req(1'b1, 3'd2, 32'h4, 32'h88776655);
        run_req(1'b0, 3'd2, 32'h3, 32'h0);
        check("split_lw3", r_data, 32'h77665544);
        check("split_lw3_lat", lat, 32'd3);
        run_req(1'b0, 3'd1, 32'h3, 32'h0);
        check("split_lh3", r_data, 32'h00005544);
`else
        run_req(1'b0, 3'd1, 32'h1, 32'h0);
        check("mis_lh1_err", {31'b0, r_err}, 32'd1);
        check("mis_lh1_rdata", r_data, 32'h0);
        check("mis_lh1_nacc", acc_n, 32'd0);
        check("mis_lh1_lat", lat, 32'd1);
        run_req(1'b1, 3'd2, 32'h2, 32'h33333333);
        check("mis_sw2_err", {31'b0, r_err}, 32'd1);
        check("mis_sw2_nacc", acc_n, 32'd0);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the byte-masked data memory in the single-cycle RISC-V datapath. Accepts one load/store request at a time from the core, converts funct3 plus address into a word address, byte mask and lane-shifted write data, and returns sign/zero-extended load data. Accesses crossing a word boundary are optionally split into two sequential memory accesses. The core stalls on `o_ready` low.

## Interface
- `ADDR_W`, 32: address width of core and memory side.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  request valid; sampled only when `o_ready`=1.
- `i_we`  in  1  1 = store, 0 = load.
- `i_funct3`  in  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores use 0 SB, 1 SH, 2 SW.
- `i_addr`  in  ADDR_W  byte address.
- `i_wdata`  in  32  store data, right-aligned.
- `o_ready`  out  1  high only in IDLE.
- `o_done`  out  1  one-cycle pulse; request finished.
- `o_err`  out  1  valid with `o_done`; illegal funct3 or unsupported misalignment.
- `o_rdata`  out  32  extended load data, valid with `o_done`, held until next accept.
- `o_mem_addr`  out  ADDR_W  word-aligned address (bits [1:0]=0).
- `o_mem_wdata`  out  32  lane-shifted store data.
- `o_mem_bmask`  out  4  byte enables.
- `o_mem_wren`  out  1  write enable; memory writes on the next rising edge.
- `i_mem_rdata`  in  32  asynchronous read data for `o_mem_addr`.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE: `i_req`=1 → latch we, funct3, addr, wdata; go ACC0. Illegal funct3 (3, 6, 7; or >2 for stores) → RESP with err, no memory access.
- size sz = 1/2/4 bytes, offset off = addr[1:0]; crossing = off+sz>4.
- ACC0: `o_mem_addr`={addr[ADDR_W-1:2],2'b00}; bmask = (szmask<<off)[3:0]; wdata = wdata<<8*off; wren = we. Load: capture `i_mem_rdata`>>8*off. Next: ACC1 if crossing, else RESP.
- ACC1: address +4 (wraps modulo 2^ADDR_W); bmask = (szmask<<off)>>4; wdata = wdata>>8*(4-off). Load: OR `i_mem_rdata`<<8*(4-off) into capture. Next: RESP.
- RESP: `o_done`=1; `o_rdata` = capture truncated to sz, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW). Next: IDLE.
- Outside ACC0/ACC1: `o_mem_wren`=0, `o_mem_bmask`=0, `o_mem_addr`=0, `o_mem_wdata`=0.
- Error response: `o_rdata`=0, no write issued.

## Timing
- Reset (async, active-low): state IDLE; `o_ready`=1, all other outputs 0, capture 0. Reset asserted mid-ACC0/ACC1 drops `o_mem_wren` immediately, so the pending write is aborted.
- Accept at edge N → ACC0 in cycle N+1 → `o_done` in N+2 (non-crossing) or N+3 (crossing). `o_ready` returns in the cycle after `o_done`.
- Minimum spacing between accepts: 3 cycles non-crossing, 4 crossing.
- `i_req` while `o_ready`=0 is ignored; no queuing.
- `i_mem_rdata` sampled at the end of each ACC cycle (combinational read path).

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined: any alignment is legal; crossing accesses use ACC1; no alignment errors.
- Undefined: an address not a multiple of sz → RESP with `o_err`=1, no memory access; ACC1 is never entered (may be optimised away).

## Structure
- `lsu_pkg`: funct3 encodings as enum `lsu_op_e`, FSM enum `lsu_state_e`, size/mask helper function.
- One sub-module `lsu_align`: combinational lane shift, mask generation, load merge and extension. Shared by ACC0/ACC1/RESP.

## Test plan
- Reset mid-ACC0 of SW addr 0x10 → `o_mem_wren` drops asynchronously; word 4 unchanged; `o_ready`=1 after release.
- SW 0xAABBCCDD @0x8 → one ACC cycle, bmask 1111, wdata 0xAABBCCDD; `o_done` at N+2; LW @0x8 returns 0xAABBCCDD.
- SB 0x80 @0x5 → bmask 0010, wdata 0x00008000; LB @0x5 → 0xFFFFFF80; LBU → 0x00000080.
- Split enabled: SW 0xAABBCCDD @0x2 → ACC0 addr 0x0 bmask 1100 wdata 0xCCDD0000, ACC1 addr 0x4 bmask 0011 wdata 0x0000AABB; `o_done` at N+3.
- Split enabled: words 0x44332211 @0x0 and 0x88776655 @0x4, LW @0x3 → 0x77665544; LH @0x3 → 0x00005544.
- Split disabled: LH @0x1 → `o_err`=1, `o_rdata`=0, no ACC1. Any build: funct3=3 → `o_err`=1, no write.
